// File: rtl/multi_digit_display_pkg.sv
// Shared FSM state, segment patterns and digit codes for the multi-digit display.
package multi_digit_display_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } state_t;

   // Active-low segment patterns, bit 6 = g ... bit 0 = a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1011000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/multi_digit_display_bcd_digit_decoder.sv
// One BCD digit code to active-low seven-segment pattern; any non-decimal code is blank.
module bcd_digit_decoder
   import multi_digit_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_c
);

   always_comb begin
      seg_c = SEG_BLANK;
      case (code)
         4'd0:    seg_c = SEG_0;
         4'd1:    seg_c = SEG_1;
         4'd2:    seg_c = SEG_2;
         4'd3:    seg_c = SEG_3;
         4'd4:    seg_c = SEG_4;
         4'd5:    seg_c = SEG_5;
         4'd6:    seg_c = SEG_6;
         4'd7:    seg_c = SEG_7;
         4'd8:    seg_c = SEG_8;
         4'd9:    seg_c = SEG_9;
         default: seg_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/multi_digit_display.sv
// Binary-to-decimal multiplexed seven-segment driver: sequential double dabble
// conversion feeding a free-running digit scanner.
module multi_digit_display
   import multi_digit_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned WIDTH      = 14,
   parameter int unsigned SCAN_DIV   = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      value,
   input  logic                  load,
   input  logic                  blank_lz,
   output logic                  ready,
   output logic                  done,
   output logic                  overflow,
   output logic [6:0]            segment,
   output logic [NUM_DIGITS-1:0] anode_L
);

   // Enough BCD digits to hold 2^WIDTH-1, never fewer than the displayed digits
   localparam int unsigned CONV_MIN    = (WIDTH * 30103 + 99999) / 100000;
   localparam int unsigned CONV_DIGITS = (CONV_MIN > NUM_DIGITS) ? CONV_MIN : NUM_DIGITS;
   localparam int unsigned BCD_W       = 4 * CONV_DIGITS;
   localparam int unsigned SH_W        = BCD_W + WIDTH;
   localparam int unsigned DISP_W      = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W       = $clog2(WIDTH + 1);
   localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned PRE_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t               state, state_d;
   logic [SH_W-1:0]      shreg, shreg_d, step_src, stepped;
   logic [CNT_W-1:0]     steps, steps_d;
   logic                 done_d, ovf_d, ready_d;
   logic                 blank_q, blank_d, blank_sel;
   logic [DISP_W-1:0]    digits, digits_d;
   logic [BCD_W-1:0]     bcd;
   logic                 finish, seen;
   logic [3:0]           dig;
   logic [PRE_W-1:0]     prescale, prescale_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic [3:0]           sel_code;
   logic [6:0]           dec_seg, segment_d;
   logic [NUM_DIGITS-1:0] anode_d;

   // One double dabble step: add 3 to every BCD digit >= 5, then shift left
   function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int i = 0; i < int'(CONV_DIGITS); i++) begin
         if (t[WIDTH + 4*i +: 4] >= 4'd5)
            t[WIDTH + 4*i +: 4] = t[WIDTH + 4*i +: 4] + 4'd3;
      end
      return t << 1;
   endfunction

   assign step_src = (state == IDLE) ? {BCD_W'(0), value} : shreg;
   assign stepped  = dd_step(step_src);
   assign bcd      = stepped[WIDTH +: BCD_W];
   assign blank_sel = (state == IDLE) ? blank_lz : blank_q;

   // Conversion FSM, final digit/overflow commit
   always_comb begin
      state_d  = state;
      shreg_d  = shreg;
      steps_d  = steps;
      blank_d  = blank_q;
      done_d   = 1'b0;
      ovf_d    = overflow;
      digits_d = digits;
      finish   = 1'b0;
      seen     = 1'b0;
      dig      = 4'd0;

      case (state)
         IDLE: begin
            if (load) begin
               state_d = CONVERT;
               shreg_d = stepped;
               steps_d = CNT_W'(1);
               blank_d = blank_lz;
               finish  = (WIDTH == 1);
            end
         end
         CONVERT: begin
            if (done) begin
               state_d = IDLE;
            end else begin
               shreg_d = stepped;
               steps_d = steps + CNT_W'(1);
               finish  = (steps == CNT_W'(WIDTH - 1));
            end
         end
         default: state_d = IDLE;
      endcase

      if (finish) begin
         done_d = 1'b1;
         ovf_d  = 1'b0;
         for (int i = int'(NUM_DIGITS); i < int'(CONV_DIGITS); i++)
            if (bcd[4*i +: 4] != 4'd0) ovf_d = 1'b1;
         for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            dig = bcd[4*i +: 4];
            if (dig != 4'd0) seen = 1'b1;
            digits_d[4*i +: 4] = (blank_sel && !seen && (i != 0)) ? BLANK_CODE : dig;
         end
      end

      ready_d = (state_d == IDLE);
   end

   // Scan prescaler and digit index
   always_comb begin
      prescale_d = prescale + PRE_W'(1);
      idx_d      = idx;
      if (prescale == PRE_W'(SCAN_DIV - 1)) begin
         prescale_d = PRE_W'(0);
         idx_d      = (idx == IDX_W'(NUM_DIGITS - 1)) ? IDX_W'(0) : idx + IDX_W'(1);
      end
      sel_code  = digits_d[{idx_d, 2'b00} +: 4];
      segment_d = ovf_d ? SEG_DASH : dec_seg;
      anode_d   = ~(NUM_DIGITS'(1) << idx_d);
   end

   bcd_digit_decoder u_dec (
      .code  (sel_code),
      .seg_c (dec_seg)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         shreg    <= '0;
         steps    <= '0;
         blank_q  <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         ready    <= 1'b1;
         digits   <= {NUM_DIGITS{BLANK_CODE}};
         prescale <= '0;
         idx      <= '0;
         segment  <= SEG_BLANK;
         anode_L  <= ~(NUM_DIGITS'(1));
      end else begin
         state    <= state_d;
         shreg    <= shreg_d;
         steps    <= steps_d;
         blank_q  <= blank_d;
         done     <= done_d;
         overflow <= ovf_d;
         ready    <= ready_d;
         digits   <= digits_d;
         prescale <= prescale_d;
         idx      <= idx_d;
         segment  <= segment_d;
         anode_L  <= anode_d;
      end
   end

endmodule

// File: tb/tb_multi_digit_display.sv
// Bench for multi_digit_display: directed literal checks plus random traffic
// compared every cycle against a decimal-arithmetic model.
module tb_multi_digit_display;

   localparam int ND = 4;
   localparam int W  = 14;
   localparam int SD = 4;

   logic          clock = 1'b0;
   logic          reset, load, blank_lz;
   logic [W-1:0]  value;
   logic          ready, done, overflow;
   logic [6:0]    segment;
   logic [ND-1:0] anode_L;

   int n_checks = 0;
   int n_errors = 0;

   multi_digit_display #(.NUM_DIGITS(ND), .WIDTH(W), .SCAN_DIV(SD)) dut (
      .clock    (clock),
      .reset    (reset),
      .value    (value),
      .load     (load),
      .blank_lz (blank_lz),
      .ready    (ready),
      .done     (done),
      .overflow (overflow),
      .segment  (segment),
      .anode_L  (anode_L)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   // Reference model: decimal arithmetic on the shown integer plus a busy countdown
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1011000, 7'b0000000, 7'b0010000};
   int pow10 [ND] = '{1, 10, 100, 1000};
   int  m_busy, m_tick, m_dval, m_pend;
   bit  m_valid = 0, m_blank_all, m_dbl, m_pbl;

   function automatic logic [6:0] exp_seg(input int i);
      if (m_blank_all)                          return 7'b1111111;
      if (m_dval > 9999)                        return 7'b0111111;
      if (m_dbl && i > 0 && m_dval < pow10[i])  return 7'b1111111;
      return seg_tab[(m_dval / pow10[i]) % 10];
   endfunction

   always @(negedge clock) begin
      int idx;
      logic [ND-1:0] an;
      if (m_valid) begin
         idx = (m_tick / SD) % ND;
         an  = ~(ND'(1) << idx);
         check("ready",    32'(ready),    32'(m_busy == 0));
         check("done",     32'(done),     32'(m_busy == 1));
         check("overflow", 32'(overflow), 32'(!m_blank_all && m_dval > 9999));
         check("anode_L",  32'(anode_L),  32'(an));
         check("segment",  32'(segment),  32'(exp_seg(idx)));
      end
      if (reset) begin
         m_valid     = 1;
         m_busy      = 0;
         m_tick      = 0;
         m_blank_all = 1;
      end else if (m_valid) begin
         m_tick++;
         if (m_busy == 0 && load) begin
            m_busy = W;
            m_pend = int'(value);
            m_pbl  = blank_lz;
         end else if (m_busy > 0) begin
            m_busy--;
         end
         if (m_busy == 1) begin
            m_dval      = m_pend;
            m_dbl       = m_pbl;
            m_blank_all = 0;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input int v, input bit bl);
      value    = W'(v);
      blank_lz = bl;
      load     = 1'b1;
      step();
      load     = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 40 && !ready; t++) step();
      if (!ready) check("idle_timeout", 32'(ready), 32'd1);
   endtask

   task automatic show_digit(input int i, input logic [6:0] exp, input string name);
      logic [ND-1:0] want;
      want = ~(ND'(1) << i);
      for (int t = 0; t < 32 && anode_L !== want; t++) step();
      check({name, "_anode"}, 32'(anode_L), 32'(want));
      check(name, 32'(segment), 32'(exp));
   endtask

   initial begin
      int low, dk, nd;
      logic [ND-1:0] seq [4];
      seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
      repeat (2) step();
      check("rst_ready",   32'(ready),    32'd1);
      check("rst_done",    32'(done),     32'd0);
      check("rst_ovf",     32'(overflow), 32'd0);
      check("rst_segment", 32'(segment),  32'h7F);
      check("rst_anode",   32'(anode_L),  32'(4'b1110));
      reset = 1'b0;
      step();

      // 1234: latency, done position, digit patterns
      do_load(1234, 1'b0);
      low = 0; dk = 0; nd = 0;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin nd++; if (dk == 0) dk = k; end
         if (ready) break;
         low++;
         step();
      end
      check("busy_cycles", 32'(low), 32'd14);
      check("done_cycle",  32'(dk),  32'd14);
      check("done_count",  32'(nd),  32'd1);
      show_digit(0, 7'b0011001, "d1234_0");
      show_digit(1, 7'b0110000, "d1234_1");
      show_digit(2, 7'b0100100, "d1234_2");
      show_digit(3, 7'b1111001, "d1234_3");

      // 7 with and without leading-zero blanking
      do_load(7, 1'b1); wait_idle();
      show_digit(0, 7'b1011000, "d7b_0");
      for (int i = 1; i < ND; i++) show_digit(i, 7'b1111111, "d7b_hi");
      do_load(7, 1'b0); wait_idle();
      for (int i = 1; i < ND; i++) show_digit(i, 7'b1000000, "d7z_hi");

      // 0 blanked, then overflow
      do_load(0, 1'b1); wait_idle();
      show_digit(0, 7'b1000000, "d0_0");
      for (int i = 1; i < ND; i++) show_digit(i, 7'b1111111, "d0_hi");
      do_load(12000, 1'b0); wait_idle();
      check("ovf_flag", 32'(overflow), 32'd1);
      for (int i = 0; i < ND; i++) show_digit(i, 7'b0111111, "ovf_dash");

      // load during conversion is dropped
      do_load(42, 1'b0);
      repeat (4) step();
      value = W'(99); load = 1'b1;
      step();
      load = 1'b0;
      nd = 0;
      for (int k = 0; k < 30; k++) begin if (done) nd++; step(); end
      check("drop_done_count", 32'(nd), 32'd1);
      show_digit(0, 7'b0100100, "d42_0");
      show_digit(1, 7'b0011001, "d42_1");
      show_digit(2, 7'b1000000, "d42_2");
      show_digit(3, 7'b1000000, "d42_3");

      // reset mid-conversion, then idle scan sequence
      do_load(9999, 1'b0);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         check("scan_anode", 32'(anode_L), 32'(seq[(k / 4) % 4]));
         check("abort_seg",  32'(segment), 32'h7F);
         check("abort_done", 32'(done),    32'd0);
         check("abort_ready", 32'(ready),  32'd1);
         step();
      end

      // random traffic, checked by the model
      for (int c = 0; c < 3000; c++) begin
         case ($urandom_range(0, 3))
            0:       value = W'($urandom_range(0, 9));
            1:       value = W'($urandom_range(0, 9999));
            2:       value = W'($urandom_range(9990, 16383));
            default: value = W'($urandom_range(0, 16383));
         endcase
         blank_lz = 1'($urandom_range(0, 1));
         load     = ($urandom_range(0, 5) == 0);
         reset    = ($urandom_range(0, 299) == 0);
         step();
      end
      reset = 1'b0; load = 1'b0;
      repeat (20) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
